fc_out_accum: RTL and testbench

//  Output fully-connected layer accumulator. It sits directly upstream of the 10-class argmax comparator.
//  It consumes a stream of hidden-layer activations, each beat carrying NUM_CLS weights.
//  It performs NUM_CLS parallel signed MACs over N_IN beats.
//  It then presents the packed class scores on layer_out with a one-cycle out_valid pulse.

---
 rtl/fc_out_accum.sv | 166 ++++++++++++++++
 tb/tb_fc_out_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_out_accum.sv
`default_nettype none
// ============================================================================
// Module   : fc_out_accum
// Brief    : Output FC layer, NUM_CLS parallel signed MACs over N_IN beats,
//            packed class scores presented with a one-cycle out_valid pulse.
//            Optional saturating accumulation: define FC_ACC_SAT_EN.
// Revision : 1.0
// ============================================================================
module fc_out_accum #(
    parameter int N_IN    = 64,
    parameter int NUM_CLS = 10,
    parameter int ACT_W   = 8,
    parameter int WGT_W   = 8,
    parameter int ACC_W   = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ACT_W-1:0]           in_act,
    input  logic [NUM_CLS*WGT_W-1:0]   in_wgt,
    input  logic                       in_last,
    output logic [NUM_CLS*ACC_W-1:0]   layer_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       err_len,
    output logic                       sat_hit
);

    localparam int PROD_W = ACT_W + WGT_W;
    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     final_beat;
    logic                     load;
    logic                     accum;
    logic                     publish;
    logic signed [PROD_W-1:0] act_ext;
    logic signed [ACC_W-1:0]  acc      [NUM_CLS];
    logic signed [ACC_W-1:0]  prod_ext [NUM_CLS];
    logic signed [ACC_W-1:0]  acc_sum  [NUM_CLS];
`ifdef FC_ACC_SAT_EN
    logic [NUM_CLS-1:0]       ovf;
    logic                     sat_reg;
`endif

    assign final_beat = (beat_cnt == LAST_CNT);
    assign busy       = (state == S_ACC) || (state == S_DONE);
    assign act_ext    = PROD_W'($signed(in_act));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        accum      = 1'b0;
        publish    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accum = 1'b1;
                    if (final_beat) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                publish    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Products are exact in PROD_W bits, so sign-extending to ACC_W is lossless.
    for (genvar k = 0; k < NUM_CLS; k++) begin : g_mac
        logic signed [PROD_W-1:0] wgt_ext;
        logic signed [PROD_W-1:0] prod;
        assign wgt_ext     = PROD_W'($signed(in_wgt[k*WGT_W +: WGT_W]));
        assign prod        = act_ext * wgt_ext;
        assign prod_ext[k] = ACC_W'(prod);
`ifdef FC_ACC_SAT_EN
        logic [ACC_W:0] wide;
        assign wide       = {acc[k][ACC_W-1], acc[k]} + {prod_ext[k][ACC_W-1], prod_ext[k]};
        assign ovf[k]     = wide[ACC_W] ^ wide[ACC_W-1];
        assign acc_sum[k] = !ovf[k]     ? wide[ACC_W-1:0] :
                            wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                          {1'b0, {(ACC_W-1){1'b1}}};
`else
        assign acc_sum[k] = acc[k] + prod_ext[k];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            err_len   <= 1'b0;
            layer_out <= '0;
            for (int k = 0; k < NUM_CLS; k++) begin
                acc[k] <= '0;
            end
        end else begin
            out_valid <= publish;
            if (load) begin
                beat_cnt <= CNT_W'(1);
                for (int k = 0; k < NUM_CLS; k++) begin
                    acc[k] <= prod_ext[k];
                end
            end else if (accum) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                for (int k = 0; k < NUM_CLS; k++) begin
                    acc[k] <= acc_sum[k];
                end
            end else if (publish) begin
                beat_cnt <= '0;
                for (int k = 0; k < NUM_CLS; k++) begin
                    layer_out[k*ACC_W +: ACC_W] <= acc[k];
                end
            end
            // Frame length is governed by beat_cnt; in_last is only audited.
            if ((load || accum) && (in_last != final_beat)) begin
                err_len <= 1'b1;
            end
        end
    end

`ifdef FC_ACC_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_reg <= 1'b0;
        end else if (accum && (|ovf)) begin
            sat_reg <= 1'b1;
        end
    end
    assign sat_hit = sat_reg;
`else
    assign sat_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_out_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_out_accum
// Brief    : Directed self-checking bench for fc_out_accum (N_IN=4; a 30-bit
//            and a 16-bit accumulator instance share one input stream).
// Revision : 1.0
// ============================================================================
module tb_fc_out_accum;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_act;
    logic [79:0]  in_wgt;
    logic         in_last;

    logic         in_ready,  out_valid,  busy,  err_len,  sat_hit;
    logic [299:0] layer_out;
    logic         in_ready_16, out_valid_16, busy_16, err_len_16, sat_hit_16;
    logic [159:0] layer_out_16;

    int checks   = 0;
    int failures = 0;

    localparam logic [79:0] W_PM  = {8'hFF, 64'h0, 8'h01};
    localparam logic [79:0] W_ONE = {10{8'h01}};
    localparam logic [79:0] W_MAX = {10{8'h7F}};

    always #5 clk = ~clk;

    fc_out_accum #(.N_IN(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
        .layer_out(layer_out), .out_valid(out_valid), .busy(busy),
        .err_len(err_len), .sat_hit(sat_hit)
    );

    fc_out_accum #(.N_IN(4), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_16),
        .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
        .layer_out(layer_out_16), .out_valid(out_valid_16), .busy(busy_16),
        .err_len(err_len_16), .sat_hit(sat_hit_16)
    );

    function automatic logic [299:0] pack30(input int c0, input int c9);
        logic [299:0] r;
        r          = '0;
        r[29:0]    = c0[29:0];
        r[299:270] = c9[29:0];
        return r;
    endfunction

    function automatic logic [299:0] pack_all30(input int v);
        logic [299:0] r;
        for (int k = 0; k < 10; k++) r[k*30 +: 30] = v[29:0];
        return r;
    endfunction

    // Presents one beat from just after a negedge and returns at the negedge after acceptance.
    task automatic beat(input logic [7:0] a, input logic [79:0] w, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1; in_act = a; in_wgt = w; in_last = l;
        while (!in_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL rst_err_len: got %b expected 0", err_len); end
        checks++; if (sat_hit !== 1'b0 || sat_hit_16 !== 1'b0) begin failures++; $display("FAIL rst_sat_hit: got %b/%b expected 0/0", sat_hit, sat_hit_16); end
        checks++; if (layer_out !== '0 || layer_out_16 !== '0) begin failures++; $display("FAIL rst_layer_out: got %h / %h expected 0", layer_out, layer_out_16); end
    endtask

    task automatic test_basic();
        beat(8'd1, W_PM, 1'b0); beat(8'd2, W_PM, 1'b0);
        beat(8'd3, W_PM, 1'b0); beat(8'd4, W_PM, 1'b1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_done_state: got ov=%b rdy=%b busy=%b expected 0/0/1", out_valid, in_ready, busy); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_pulse: got %b expected 1", out_valid); end
        checks++; if (layer_out !== pack30(10, -10)) begin failures++; $display("FAIL basic_scores: got %h expected %h", layer_out, pack30(10, -10)); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || layer_out !== pack30(10, -10)) begin failures++; $display("FAIL basic_pulse_end: got ov=%b out=%h expected 0 and held", out_valid, layer_out); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL basic_err_len: got %b expected 0", err_len); end
    endtask

    task automatic test_gaps();
        int bad_rdy;
        bad_rdy = 0;
        for (int i = 1; i <= 4; i++) begin
            beat(8'(i), W_PM, i == 4);
            if (i < 4) begin
                if (in_ready !== 1'b1) bad_rdy++;
                @(negedge clk);
            end
        end
        checks++; if (bad_rdy != 0) begin failures++; $display("FAIL gaps_in_ready: got %0d low gap cycles expected 0", bad_rdy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gaps_done_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || layer_out !== pack30(10, -10)) begin failures++; $display("FAIL gaps_scores: got ov=%b out=%h expected 1 %h", out_valid, layer_out, pack30(10, -10)); end
        @(negedge clk);
    endtask

    task automatic test_last_err();
        do_reset();
        beat(8'd1, W_PM, 1'b0); beat(8'd2, W_PM, 1'b1);
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL last_err_set: got %b expected 1", err_len); end
        beat(8'd3, W_PM, 1'b0); beat(8'd4, W_PM, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || layer_out !== pack30(10, -10)) begin failures++; $display("FAIL last_err_scores: got ov=%b out=%h expected 1 %h", out_valid, layer_out, pack30(10, -10)); end
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL last_err_sticky: got %b expected 1", err_len); end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int pulses;
        pulses = 0;
        beat(8'd1, W_ONE, 1'b0); beat(8'd1, W_ONE, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || err_len !== 1'b0 || layer_out !== '0) begin failures++; $display("FAIL midrst_state: got busy=%b err=%b out=%h expected 0/0/0", busy, err_len, layer_out); end
        repeat (4) begin
            if (out_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
        for (int i = 0; i < 4; i++) beat(8'd1, W_ONE, i == 3);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || layer_out !== pack_all30(4)) begin failures++; $display("FAIL midrst_clean_frame: got ov=%b out=%h expected 1 %h", out_valid, layer_out, pack_all30(4)); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [159:0] exp16;
        logic         exp_sat;
`ifdef FC_ACC_SAT_EN
        exp16 = {10{16'h7FFF}}; exp_sat = 1'b1;
`else
        exp16 = {10{16'hFC04}}; exp_sat = 1'b0;
`endif
        for (int i = 0; i < 4; i++) beat(8'd127, W_MAX, i == 3);
        @(negedge clk);
        checks++; if (out_valid_16 !== 1'b1 || layer_out_16 !== exp16) begin failures++; $display("FAIL sat16_scores: got ov=%b out=%h expected 1 %h", out_valid_16, layer_out_16, exp16); end
        checks++; if (sat_hit_16 !== exp_sat) begin failures++; $display("FAIL sat16_flag: got %b expected %b", sat_hit_16, exp_sat); end
        checks++; if (layer_out !== pack_all30(64516) || sat_hit !== 1'b0) begin failures++; $display("FAIL sat30_no_sat: got out=%h sat=%b expected %h 0", layer_out, sat_hit, pack_all30(64516)); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int held_bad;
        held_bad = 0;
        for (int i = 1; i <= 4; i++) beat(8'(i), W_PM, i == 4);
        in_valid = 1'b1; in_act = 8'd2; in_wgt = W_PM; in_last = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || layer_out !== pack30(10, -10)) begin failures++; $display("FAIL b2b_frame1: got ov=%b out=%h expected 1 %h", out_valid, layer_out, pack30(10, -10)); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            if (out_valid !== 1'b0 || layer_out !== pack30(10, -10)) held_bad++;
            beat(8'd2, W_PM, i == 4);
        end
        if (out_valid !== 1'b0 || layer_out !== pack30(10, -10)) held_bad++;
        checks++; if (held_bad != 0) begin failures++; $display("FAIL b2b_hold: got %0d unheld samples expected 0", held_bad); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || layer_out !== pack30(8, -8)) begin failures++; $display("FAIL b2b_frame2: got ov=%b out=%h expected 1 %h", out_valid, layer_out, pack30(8, -8)); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL b2b_err_len: got %b expected 0", err_len); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_last_err();
        test_reset_midframe();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
